// File: rtl/seq_comp_nbit.sv
// seq_comp_nbit: multi-cycle slice-serial magnitude comparator (a vs b or a vs 0), MSB slice first.
// Optional COMP_EARLY_EXIT_EN: leave CMP at the first differing slice instead of after all N slices.
module seq_comp_nbit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             zero_mode,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             bg,
  output logic             les,
  output logic             eq
);
  localparam int N = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [CHUNK-1:0] MSB = CHUNK'(1) << (CHUNK - 1);
  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IW-1:0] idx;
  logic sgn_r, decided, gt_r;
  logic [CHUNK-1:0] flip, sa, sb;
  logic diff, dec_now, gt_now, fin;
  // Flipping the top bit maps two's-complement order onto unsigned order.
  always_comb begin
    flip = (sgn_r && idx == LAST) ? MSB : '0;
    sa = a_r[int'(idx)*CHUNK +: CHUNK] ^ flip;
    sb = b_r[int'(idx)*CHUNK +: CHUNK] ^ flip;
    diff = sa != sb;
    dec_now = decided | diff;
    gt_now = decided ? gt_r : sa > sb;
`ifdef COMP_EARLY_EXIT_EN
    fin = idx == '0 || diff;
`else
    fin = idx == '0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      bg <= 1'b0;
      les <= 1'b0;
      eq <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      idx <= '0;
      sgn_r <= 1'b0;
      decided <= 1'b0;
      gt_r <= 1'b0;
    end else begin
      case (state)
        CMP: begin
          decided <= dec_now;
          gt_r <= gt_now;
          idx <= idx - 1'b1;
          if (fin) begin
            bg <= dec_now & gt_now;
            les <= dec_now & ~gt_now;
            eq <= ~dec_now;
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          done <= 1'b0;
          state <= start ? CMP : IDLE;
          if (start) begin
            a_r <= a;
            b_r <= zero_mode ? '0 : b;
            sgn_r <= is_signed;
            idx <= LAST;
            decided <= 1'b0;
            gt_r <= 1'b0;
            busy <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule
